grid_draw_ctrl: RTL and testbench

GRID_DRAW_CTRL -- requirements
Module: grid_draw_ctrl

---
 rtl/bitc_pkg.sv | 38 +++
 rtl/grid_pixel_scanner.sv | 57 +++++
 rtl/grid_draw_ctrl.sv | 157 +++++++++++++++
 tb/tb_grid_draw_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitc_pkg.sv
// Shared types and constants for the beat-grid drawing blocks.
package bitc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } draw_state_t;

  localparam logic [2:0] C_BLACK = 3'b000;
  localparam logic [2:0] C_BLUE  = 3'b001;
  localparam logic [2:0] C_GREEN = 3'b010;
  localparam logic [2:0] C_RED   = 3'b100;
  localparam logic [2:0] C_WHITE = 3'b111;

  localparam int GRID_COLS = 16;
  localparam int GRID_ROWS = 4;

  // Cell colour priority: playhead beats selection, selection beats plain notes.
  function automatic logic [2:0] cell_colour(input logic on, input logic playhead,
                                             input logic selected);
    logic [2:0] c;
    if (playhead && on) begin
      c = C_WHITE;
    end else if (playhead) begin
      c = C_BLUE;
    end else if (selected && on) begin
      c = C_RED;
    end else if (on) begin
      c = C_GREEN;
    end else begin
      c = C_BLACK;
    end
    return c;
  endfunction

endpackage

// File: rtl/grid_pixel_scanner.sv
// Nested px/py/col/track counters walking one grid frame, one pixel per step.
module grid_pixel_scanner
  import bitc_pkg::*;
#(
  parameter int CELL_W = 8,
  parameter int CELL_H = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  output logic [7:0] px,
  output logic [6:0] py,
  output logic [3:0] col,
  output logic [1:0] track,
  output logic       last
);

  logic at_end;

  assign at_end = (px == 8'(CELL_W - 1)) && (py == 7'(CELL_H - 1)) &&
                  (col == 4'(GRID_COLS - 1)) && (track == 2'(GRID_ROWS - 1));
  assign last   = step & at_end;

  // px is innermost; each wrap carries into the next counter out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px    <= 8'd0;
      py    <= 7'd0;
      col   <= 4'd0;
      track <= 2'd0;
    end else if (clear) begin
      px    <= 8'd0;
      py    <= 7'd0;
      col   <= 4'd0;
      track <= 2'd0;
    end else if (step) begin
      if (px == 8'(CELL_W - 1)) begin
        px <= 8'd0;
        if (py == 7'(CELL_H - 1)) begin
          py <= 7'd0;
          if (col == 4'(GRID_COLS - 1)) begin
            col   <= 4'd0;
            track <= track + 2'd1;
          end else begin
            col <= col + 4'd1;
          end
        end else begin
          py <= py + 7'd1;
        end
      end else begin
        px <= px + 8'd1;
      end
    end
  end

endmodule

// File: rtl/grid_draw_ctrl.sv
// Redraws the 16x4 note grid into the framebuffer on start (and on beat_tick
// when GRID_PLAYHEAD_EN is defined, which also enables playhead colouring).
module grid_draw_ctrl
  import bitc_pkg::*;
#(
  parameter logic [7:0] X0     = 8'd16,
  parameter logic [6:0] Y0     = 7'd30,
  parameter int         CELL_W = 8,
  parameter int         CELL_H = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        beat_tick,
  input  logic [15:0] pattern0,
  input  logic [15:0] pattern1,
  input  logic [15:0] pattern2,
  input  logic [15:0] pattern3,
  input  logic [3:0]  sel_track,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic [3:0]  beat,
  output logic        busy,
  output logic        done
);

`ifdef GRID_PLAYHEAD_EN
  localparam logic PLAYHEAD_ON = 1'b1;
`else
  localparam logic PLAYHEAD_ON = 1'b0;
`endif

  draw_state_t      state, next_state;
  logic             trigger, pending, last_seen;
  logic             scan_clear, scan_step, scan_last, draw_pix;
  logic [3:0][15:0] sh_pat;
  logic [3:0]       sh_sel, sh_beat;
  logic [7:0]       px, x_next;
  logic [6:0]       py, y_next;
  logic [3:0]       col;
  logic [1:0]       track;
  logic [2:0]       pix_colour;
  logic             on, playhead, gap;

  assign trigger = start | (beat_tick & PLAYHEAD_ON);

  grid_pixel_scanner #(.CELL_W(CELL_W), .CELL_H(CELL_H)) u_scan (
    .clk   (clk),
    .reset (reset),
    .clear (scan_clear),
    .step  (scan_step),
    .px    (px),
    .py    (py),
    .col   (col),
    .track (track),
    .last  (scan_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DRAW holds one cycle past the final step so the registered last pixel stays inside DRAW
  always_comb begin
    next_state = state;
    scan_clear = 1'b0;
    scan_step  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) next_state = LATCH;
        else         next_state = IDLE;
      end
      LATCH: begin
        scan_clear = 1'b1;
        next_state = DRAW;
      end
      DRAW: begin
        scan_step = ~last_seen;
        if (last_seen) next_state = DONE;
        else           next_state = DRAW;
      end
      DONE: begin
        if (pending || trigger) next_state = LATCH;
        else                    next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign draw_pix = (state == DRAW) && !last_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat      <= 4'd0;
      pending   <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      if (beat_tick) beat <= beat + 4'd1;
      if (next_state == LATCH && state != LATCH) pending <= 1'b0;
      else if (trigger && state != IDLE)          pending <= 1'b1;
      if (state == LATCH)  last_seen <= 1'b0;
      else if (scan_last)  last_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_pat  <= '0;
      sh_sel  <= 4'd0;
      sh_beat <= 4'd0;
    end else if (state == LATCH) begin
      sh_pat  <= {pattern3, pattern2, pattern1, pattern0};
      sh_sel  <= sel_track;
      sh_beat <= beat;
    end
  end

  always_comb begin
    on         = sh_pat[track][col];
    playhead   = PLAYHEAD_ON & (col == sh_beat);
    gap        = (px == 8'(CELL_W - 1)) || (py == 7'(CELL_H - 1));
    x_next     = 8'(32'(X0) + 32'(col) * 32'(CELL_W) + 32'(px));
    y_next     = 7'(32'(Y0) + 32'(track) * 32'(CELL_H) + 32'(py));
    if (gap) begin
      pix_colour = C_BLACK;
    end else begin
      pix_colour = cell_colour(on, playhead, sh_sel[track]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= draw_pix;
      busy <= (next_state == LATCH) || (next_state == DRAW);
      done <= (next_state == DONE);
      if (draw_pix) begin
        x      <= x_next;
        y      <= y_next;
        colour <= pix_colour;
      end
    end
  end

endmodule

// File: tb/tb_grid_draw_ctrl.sv
// Scoreboard bench for grid_draw_ctrl: frames are queued as they are triggered, pixels checked as plotted.
module tb_grid_draw_ctrl;
  import bitc_pkg::*;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int FRAME = 16 * 4 * W * H;
`ifdef GRID_PLAYHEAD_EN
  localparam int PH = 1;
`else
  localparam int PH = 0;
`endif

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, beat_tick = 1'b0;
  logic [15:0] pattern0 = 16'h0, pattern1 = 16'h0, pattern2 = 16'h0, pattern3 = 16'h0;
  logic [3:0]  sel_track = 4'h0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;
  logic [3:0]  beat;

  grid_draw_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .beat_tick(beat_tick),
    .pattern0(pattern0), .pattern1(pattern1), .pattern2(pattern2), .pattern3(pattern3),
    .sel_track(sel_track), .x(x), .y(y), .colour(colour), .plot(plot),
    .beat(beat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] pat;
    logic [3:0]       sel;
    logic [3:0]       bt;
  } frame_t;

  frame_t frame_q[$];
  int checks = 0, failures = 0;
  int pix_idx = 0, plot_total = 0, done_total = 0, plots_since_done = 0, busy_total = 0;
  int probe_on = -1, probe_gap = -1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_x(input int idx);
    return (16 + ((idx / (W * H)) % 16) * W + idx % W) % 256;
  endfunction

  function automatic int exp_y(input int idx);
    return (30 + (idx / (W * H * 16)) * H + (idx / W) % H) % 128;
  endfunction

  function automatic int exp_colour(input frame_t f, input int idx);
    int px = idx % W;
    int py = (idx / W) % H;
    int cl = (idx / (W * H)) % 16;
    int tr = idx / (W * H * 16);
    bit on, ph;
    if (px == W - 1 || py == H - 1) return 0;
    on = f.pat[tr][cl];
    ph = (PH == 1) && (cl == int'(f.bt));
    if (ph && on) return 7;
    if (ph) return 1;
    if (f.sel[tr] && on) return 4;
    if (on) return 2;
    return 0;
  endfunction

  // Pixel scoreboard and done/busy bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      frame_q.delete();
      pix_idx = 0;
      plots_since_done = 0;
      probe_on = -1;
      probe_gap = -1;
    end else begin
      if (busy) busy_total++;
      if (plot) begin
        plot_total++;
        plots_since_done++;
        if (int'(x) == 136 && int'(y) == 36) probe_on = int'(colour);
        if (int'(x) == 143 && int'(y) == 36) probe_gap = int'(colour);
        if (frame_q.size() == 0) begin
          check("unexpected_plot", 1, 0);
        end else begin
          check("pix_x", int'(x), exp_x(pix_idx));
          check("pix_y", int'(y), exp_y(pix_idx));
          check("pix_colour", int'(colour), exp_colour(frame_q[0], pix_idx));
          pix_idx++;
          if (pix_idx == FRAME) begin
            void'(frame_q.pop_front());
            pix_idx = 0;
          end
        end
      end
      if (done) begin
        done_total++;
        check("plots_per_frame", plots_since_done, FRAME);
        plots_since_done = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    beat_tick = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_frame(input logic [3:0] bt);
    frame_t f;
    f.pat = {pattern3, pattern2, pattern1, pattern0};
    f.sel = sel_track;
    f.bt  = bt;
    frame_q.push_back(f);
  endtask

  initial begin
    int d0, p0, b0, n;

    // Reset state
    tick();
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_beat", int'(beat), 0);

    // Single frame, first-plot latency and origin pixel
    do_reset();
    pattern0 = 16'h0001;
    sel_track = 4'b0000;
    d0 = done_total; p0 = plot_total;
    push_frame(4'd0);
    pulse_start();
    check("lat_plot_c0", int'(plot), 0);
    check("lat_busy_c0", int'(busy), 1);
    tick();
    check("lat_plot_c1", int'(plot), 0);
    tick();
    check("lat_plot_c2", int'(plot), 1);
    check("first_x", int'(x), 16);
    check("first_y", int'(y), 30);
    check("first_colour", int'(colour), (PH == 1) ? 7 : 2);
    n = 0;
    while (!done && n < FRAME + 50) begin tick(); n++; end
    check("t1_done_seen", int'(done), 1);
    tick();
    check("t1_done_one_cycle", int'(done), 0);
    check("t1_busy_after", int'(busy), 0);
    check("t1_done_count", done_total - d0, 1);
    check("t1_plot_count", plot_total - p0, FRAME);

    // Selected-track colour and gap pixel
    do_reset();
    pattern0 = 16'h0000;
    pattern1 = 16'h8000;
    sel_track = 4'b0010;
    push_frame(4'd0);
    pulse_start();
    repeat (FRAME + 50) tick();
    check("sel_pixel_136_36", probe_on, 4);
    check("gap_pixel_143_36", probe_gap, 0);

    // 17 consecutive beat_ticks from IDLE
    do_reset();
    pattern0 = 16'hA5A5; pattern1 = 16'h0F0F; pattern2 = 16'h1234; pattern3 = 16'hFFFF;
    sel_track = 4'b0100;
    d0 = done_total; p0 = plot_total; b0 = busy_total;
    if (PH == 1) begin
      push_frame(4'd1);
      push_frame(4'd1);
    end
    beat_tick = 1'b1;
    repeat (17) tick();
    beat_tick = 1'b0;
    check("t3_beat", int'(beat), 1);
    repeat (3 * FRAME) tick();
    check("t3_done_count", done_total - d0, 2 * PH);
    check("t3_plot_count", plot_total - p0, 2 * PH * FRAME);
    check("t3_busy_seen", int'(busy_total - b0 > 0), PH);
    check("t3_queue_drained", frame_q.size(), 0);

    // Start, then three beat_ticks and a pattern change during DRAW
    do_reset();
    pattern0 = 16'h00FF; pattern1 = 16'h1111; pattern2 = 16'h0000; pattern3 = 16'h8001;
    sel_track = 4'b1000;
    d0 = done_total; p0 = plot_total;
    push_frame(4'd0);
    pulse_start();
    repeat (100) tick();
    pattern2 = 16'hF0F0;
    for (int k = 0; k < 3; k++) begin
      beat_tick = 1'b1;
      tick();
      beat_tick = 1'b0;
      repeat (5) tick();
    end
    if (PH == 1) push_frame(4'd3);
    check("t4_beat", int'(beat), 3);
    repeat (2 * FRAME + 200) tick();
    check("t4_done_count", done_total - d0, 1 + PH);
    check("t4_plot_count", plot_total - p0, (1 + PH) * FRAME);
    check("t4_queue_drained", frame_q.size(), 0);

    // Reset in the middle of a frame
    do_reset();
    pattern0 = 16'h5555;
    sel_track = 4'b0001;
    push_frame(4'd0);
    pulse_start();
    beat_tick = 1'b1;
    tick();
    beat_tick = 1'b0;
    p0 = plot_total;
    n = 0;
    while (plot_total - p0 < 1000 && n < 2000) begin tick(); n++; end
    check("t5_reached_1000", int'(plot_total - p0 >= 1000), 1);
    reset = 1'b1;
    #1;
    check("t5_plot_cleared", int'(plot), 0);
    check("t5_busy_cleared", int'(busy), 0);
    check("t5_beat_cleared", int'(beat), 0);
    tick();
    reset = 1'b0;
    d0 = done_total; p0 = plot_total;
    repeat (FRAME + 200) tick();
    check("t5_no_done", done_total - d0, 0);
    check("t5_no_plot", plot_total - p0, 0);
    check("t5_beat_after", int'(beat), 0);

    // Lone beat_tick while IDLE
    do_reset();
    pattern0 = 16'h0003;
    sel_track = 4'b0000;
    d0 = done_total; p0 = plot_total;
    if (PH == 1) push_frame(4'd1);
    beat_tick = 1'b1;
    tick();
    beat_tick = 1'b0;
    check("t6_beat_inc", int'(beat), 1);
    check("t6_busy", int'(busy), PH);
    repeat (FRAME + 200) tick();
    check("t6_plot_count", plot_total - p0, PH * FRAME);
    check("t6_done_count", done_total - d0, PH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
